// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: data-cache req/ack handshake, load alignment, WB bus packing
module mem_stage #(
   parameter int EXE_MEM_BUS_WIDTH = 154,
   parameter int MEM_WB_BUS_WIDTH  = 118
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         MEM_valid,
   input  logic [EXE_MEM_BUS_WIDTH-1:0] EXE_MEM_bus_r,
   input  logic                         WB_allow_in,
   output logic                         dreq,
   output logic                         dwr,
   output logic [3:0]                   dwstrb,
   output logic [31:0]                  daddr,
   output logic [31:0]                  dwdata,
   input  logic                         dack,
   input  logic [31:0]                  drdata,
   output logic                         MEM_over,
   output logic [MEM_WB_BUS_WIDTH-1:0]  MEM_WB_bus,
   output logic [4:0]                   MEM_wdest,
   output logic [31:0]                  MEM_pc
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] load_q, load_d;

   logic        ld, st, ls_word, lb_sign;
   logic [31:0] store_data, exe_result;
   logic        mem_op;
   logic [7:0]  load_byte;
   logic [31:0] load_aligned;
   logic [31:0] rf_wdata;

   assign {ld, st, ls_word, lb_sign} = EXE_MEM_bus_r[153:150];
   assign store_data = EXE_MEM_bus_r[149:118];
   assign exe_result = EXE_MEM_bus_r[117:86];
   assign mem_op     = MEM_valid & (ld | st);

   // Cache-facing fields depend only on the latched bus, so they stay stable while waiting.
   assign daddr  = ls_word ? {exe_result[31:2], 2'b00} : exe_result;
   assign dwr    = st;
   assign dwstrb = !st ? 4'b0000 : (ls_word ? 4'b1111 : (4'b0001 << exe_result[1:0]));
   assign dwdata = ls_word ? store_data : {4{store_data[7:0]}};

   assign load_byte    = 8'(drdata >> {exe_result[1:0], 3'b000});
   assign load_aligned = ls_word ? drdata
                       : {{24{lb_sign & load_byte[7]}}, load_byte};

   always_comb begin
      state_d  = state_q;
      dreq     = 1'b0;
      MEM_over = 1'b0;
      case (state_q)
         S_IDLE: begin
            MEM_over = MEM_valid & ~mem_op;
            if (mem_op) begin
               dreq    = 1'b1;
               state_d = dack ? S_DONE : S_WAIT;
            end
         end
         S_WAIT: begin
            dreq = 1'b1;
            if (dack) state_d = S_DONE;
         end
         S_DONE: begin
            MEM_over = 1'b1;
            if (WB_allow_in) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      load_d = load_q;
      if (dreq && dack) load_d = load_aligned;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         load_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         load_q  <= load_d;
      end
   end

   assign rf_wdata   = ld ? load_q : exe_result;
   assign MEM_WB_bus = {rf_wdata, EXE_MEM_bus_r[85:0]};
   assign MEM_wdest  = EXE_MEM_bus_r[36:32] & {5{MEM_valid}};
   assign MEM_pc     = EXE_MEM_bus_r[31:0];

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

   logic         clk = 1'b0;
   logic         rst, MEM_valid, WB_allow_in, dack;
   logic [153:0] bus;
   logic [31:0]  drdata;
   logic         dreq, dwr, MEM_over;
   logic [3:0]   dwstrb;
   logic [31:0]  daddr, dwdata, MEM_pc;
   logic [117:0] MEM_WB_bus;
   logic [4:0]   MEM_wdest;

   int n_cmp = 0;
   int n_err = 0;
   int hs_cnt = 0;
   int hs_base;

   mem_stage dut (
      .clk(clk), .rst(rst), .MEM_valid(MEM_valid), .EXE_MEM_bus_r(bus),
      .WB_allow_in(WB_allow_in), .dreq(dreq), .dwr(dwr), .dwstrb(dwstrb),
      .daddr(daddr), .dwdata(dwdata), .dack(dack), .drdata(drdata),
      .MEM_over(MEM_over), .MEM_WB_bus(MEM_WB_bus), .MEM_wdest(MEM_wdest),
      .MEM_pc(MEM_pc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (dreq && dack) hs_cnt++;

   function automatic logic [153:0] mk(input logic ld, input logic st, input logic lw,
                                       input logic sg, input logic [31:0] sd,
                                       input logic [31:0] ea, input logic [4:0] wd,
                                       input logic [31:0] pc);
      return {ld, st, lw, sg, sd, ea, 32'h0BAD_F00D, 6'b101010, 8'h5A, 2'b01, 1'b1, wd, pc};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds dack low for 'delay' cycles, then pulses it with rdata; ends in DONE.
   task automatic do_mem(input int delay, input logic [31:0] rdata);
      for (int i = 0; i < delay; i++) tick();
      dack = 1'b1;
      drdata = rdata;
      tick();
      dack = 1'b0;
      drdata = 32'h0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; MEM_valid = 1'b0; WB_allow_in = 1'b1; dack = 1'b0;
      drdata = 32'h0; bus = '0;
      tick(); tick();
      chk("rst_dreq", 32'(dreq), 32'd0);
      chk("rst_over", 32'(MEM_over), 32'd0);
      chk("rst_wdest", 32'(MEM_wdest), 32'd0);
      rst = 1'b0;

      // non-memory passthrough
      bus = mk(0, 0, 0, 0, 32'h0, 32'h1234_5678, 5'd5, 32'h0000_0400);
      MEM_valid = 1'b1;
      #1;
      chk("alu_over", 32'(MEM_over), 32'd1);
      chk("alu_dreq", 32'(dreq), 32'd0);
      chk("alu_wdata", MEM_WB_bus[117:86], 32'h1234_5678);
      chk("alu_wdest", 32'(MEM_wdest), 32'd5);
      chk("alu_pc", MEM_pc, 32'h0000_0400);
      chk("alu_lo", MEM_WB_bus[85:54], 32'h0BAD_F00D);
      chk("alu_flags", 32'(MEM_WB_bus[53:0]), 32'({6'b101010, 8'h5A, 2'b01, 1'b1, 5'd5, 32'h0000_0400}));
      tick();

      // LW with dack three cycles late
      bus = mk(1, 0, 1, 0, 32'h0, 32'h0000_1006, 5'd7, 32'h0000_0404);
      hs_base = hs_cnt;
      #1;
      for (int c = 0; c < 4; c++) begin
         chk("lw_dreq", 32'(dreq), 32'd1);
         chk("lw_addr", daddr, 32'h0000_1004);
         chk("lw_over", 32'(MEM_over), 32'd0);
         if (c < 3) tick();
      end
      chk("lw_strb", 32'(dwstrb), 32'd0);
      chk("lw_dwr", 32'(dwr), 32'd0);
      dack = 1'b1; drdata = 32'hDEAD_BEEF;
      tick();
      dack = 1'b0; drdata = 32'h0;
      chk("lw_done_over", 32'(MEM_over), 32'd1);
      chk("lw_done_dreq", 32'(dreq), 32'd0);
      chk("lw_wdata", MEM_WB_bus[117:86], 32'hDEAD_BEEF);
      chk("lw_hs", 32'(hs_cnt - hs_base), 32'd1);
      tick();

      // LB extension cases on word 0x80FF7F01
      bus = mk(1, 0, 0, 1, 32'h0, 32'h0000_3002, 5'd8, 32'h0000_0408);
      #1;
      chk("lb2_addr", daddr, 32'h0000_3002);
      do_mem(0, 32'h80FF_7F01);
      chk("lb2_over", 32'(MEM_over), 32'd1);
      chk("lb2_wdata", MEM_WB_bus[117:86], 32'hFFFF_FFFF);
      tick();
      bus = mk(1, 0, 0, 1, 32'h0, 32'h0000_3003, 5'd8, 32'h0000_040C);
      #1;
      do_mem(0, 32'h80FF_7F01);
      chk("lb3_wdata", MEM_WB_bus[117:86], 32'hFFFF_FF80);
      tick();
      bus = mk(1, 0, 0, 0, 32'h0, 32'h0000_3000, 5'd8, 32'h0000_0410);
      #1;
      do_mem(0, 32'h80FF_7F01);
      chk("lbu0_wdata", MEM_WB_bus[117:86], 32'h0000_0001);
      tick();

      // SB then SW
      bus = mk(0, 1, 0, 0, 32'h0000_00A5, 32'h0000_2003, 5'd0, 32'h0000_0414);
      #1;
      chk("sb_dreq", 32'(dreq), 32'd1);
      chk("sb_dwr", 32'(dwr), 32'd1);
      chk("sb_strb", 32'(dwstrb), 32'b1000);
      chk("sb_data", dwdata, 32'hA5A5_A5A5);
      chk("sb_addr", daddr, 32'h0000_2003);
      do_mem(1, 32'h0);
      chk("sb_over", 32'(MEM_over), 32'd1);
      chk("sb_wdata", MEM_WB_bus[117:86], 32'h0000_2003);
      tick();
      bus = mk(0, 1, 1, 0, 32'hCAFE_BABE, 32'h0000_300A, 5'd0, 32'h0000_0418);
      #1;
      chk("sw_strb", 32'(dwstrb), 32'b1111);
      chk("sw_data", dwdata, 32'hCAFE_BABE);
      chk("sw_addr", daddr, 32'h0000_3008);
      do_mem(0, 32'h0);
      tick();

      // downstream stall: DONE held, stray dack ignored
      WB_allow_in = 1'b0;
      bus = mk(1, 0, 1, 0, 32'h0, 32'h0000_0040, 5'd9, 32'h0000_041C);
      hs_base = hs_cnt;
      #1;
      do_mem(1, 32'h1122_3344);
      for (int c = 0; c < 5; c++) begin
         chk("stall_over", 32'(MEM_over), 32'd1);
         chk("stall_dreq", 32'(dreq), 32'd0);
         chk("stall_wdata", MEM_WB_bus[117:86], 32'h1122_3344);
         dack = 1'b1; drdata = 32'h5555_5555;
         tick();
      end
      dack = 1'b0; drdata = 32'h0;
      chk("stall_hs", 32'(hs_cnt - hs_base), 32'd1);
      chk("stall_wdata_end", MEM_WB_bus[117:86], 32'h1122_3344);

      // back-to-back: next bus latched with the DONE handshake
      WB_allow_in = 1'b1;
      tick();
      bus = mk(1, 0, 1, 0, 32'h0, 32'h0000_0080, 5'd10, 32'h0000_0420);
      #1;
      chk("b2b_dreq", 32'(dreq), 32'd1);
      chk("b2b_addr", daddr, 32'h0000_0080);
      do_mem(0, 32'h0BEE_F00D);
      chk("b2b_wdata", MEM_WB_bus[117:86], 32'h0BEE_F00D);
      tick();

      // reset while waiting; late dack must not complete anything
      bus = mk(1, 0, 1, 0, 32'h0, 32'h0000_00C0, 5'd11, 32'h0000_0424);
      #1;
      tick();
      chk("rw_wait_dreq", 32'(dreq), 32'd1);
      rst = 1'b1; MEM_valid = 1'b0;
      tick();
      rst = 1'b0;
      chk("rw_dreq", 32'(dreq), 32'd0);
      chk("rw_over", 32'(MEM_over), 32'd0);
      dack = 1'b1; drdata = 32'h7777_7777;
      tick();
      dack = 1'b0;
      chk("rw_late_over", 32'(MEM_over), 32'd0);
      chk("rw_late_dreq", 32'(dreq), 32'd0);
      bus = mk(0, 0, 0, 0, 32'h0, 32'h0000_0099, 5'd3, 32'h0000_0428);
      MEM_valid = 1'b1;
      #1;
      chk("rw_idle_over", 32'(MEM_over), 32'd1);
      chk("rw_idle_dreq", 32'(dreq), 32'd0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, between the EXE and WB stages. It is the receiving end of the EXE->MEM bus. It unpacks the bus and, for loads and stores, runs a request/acknowledge transaction with the data cache, stalling until the cache answers. It aligns and extends load data and forwards the remaining write-back fields to WB unchanged.

## Interface
- EXE_MEM_BUS_WIDTH, 154, width of EXE->MEM bus
- MEM_WB_BUS_WIDTH, 118, width of MEM->WB bus
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- MEM_valid  in  1  MEM holds a valid instruction
- EXE_MEM_bus_r  in  154  registered EXE->MEM bus. MSB first: mem_control[3:0] = {load, store, ls_word, lb_sign}, store_data[31:0], exe_result[31:0] (address / ALU result), lo_result[31:0], hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr[7:0], syscall, eret, rf_wen, rf_wdest[4:0], pc[31:0]
- WB_allow_in  in  1  WB accepts the MEM instruction this cycle
- dreq  out  1  data-cache request
- dwr  out  1  1 = store, 0 = load
- dwstrb  out  4  byte write strobes
- daddr  out  32  access address
- dwdata  out  32  store data
- dack  in  1  cache accepted/completed the request; drdata valid this cycle
- drdata  in  32  load data
- MEM_over  out  1  MEM finished; may advance
- MEM_WB_bus  out  118  {rf_wdata[31:0], lo_result, hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr, syscall, eret, rf_wen, rf_wdest, pc}
- MEM_wdest  out  5  rf_wdest & {5{MEM_valid}}, for hazard detection
- MEM_pc  out  32  pc field, for display

## Operation
- mem_op = MEM_valid & (load | store). Non-memory instruction: MEM_over = MEM_valid, combinational. The FSM stays in IDLE and dreq stays 0.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: if mem_op, dreq=1. With dack, go DONE; otherwise go WAIT.
  - WAIT: dreq=1 and all d* outputs held stable. On dack, go DONE.
  - DONE: dreq=0, MEM_over=1. On WB_allow_in, go IDLE.
- Load data is captured into load_reg on the dack cycle.
- Address:
  - Word access (ls_word=1): daddr = {exe_result[31:2], 2'b00}. The low two bits are ignored; there is no alignment exception.
  - Byte access: daddr = exe_result.
- Store:
  - Word: dwstrb=4'b1111, dwdata=store_data.
  - Byte: dwstrb = 4'b0001 << exe_result[1:0], dwdata = {4{store_data[7:0]}}.
  - Load: dwstrb = 0.
- Load result:
  - Word: drdata.
  - Byte: select byte exe_result[1:0]. Sign-extend if lb_sign, else zero-extend.
- rf_wdata = load ? load_reg : exe_result. All other MEM_WB_bus fields are passed through.
- MEM_valid must not deassert while MEM_over=0 on a memory op. The top level cannot flush an outstanding request.

## Timing
- Reset (rst=1 at an edge): state→IDLE, load_reg→0. With MEM_valid=0 during reset, dreq=0, MEM_over=0, MEM_wdest=0.
- Reset mid-transaction (WAIT or DONE): the FSM is in IDLE the next cycle. dreq drops one cycle after rst is sampled. A late dack is ignored.
- Latency:
  - Non-memory op: 0 extra cycles.
  - Memory op: the minimum is dack in the first cycle, giving DONE on cycle 1 and MEM_over on cycle 1. In general, MEM_over rises 1 cycle after the dack cycle.
- dack is only sampled while dreq=1. dack while dreq=0 is ignored.
- DONE held with WB_allow_in=0: MEM_over and rf_wdata stay stable and no new request is issued.
- Back-to-back memory ops:
  - DONE→IDLE coincides with the top latching the next bus.
  - The next dreq asserts in the cycle after the DONE handshake.
  - There is never a duplicate request for the same instruction.

## Test plan
- Non-memory passthrough: exe_result=0x1234_5678, rf_wen=1, rf_wdest=5 → MEM_over=1 same cycle, dreq=0, rf_wdata=0x1234_5678, MEM_wdest=5.
- LW with 3-cycle dack delay, addr=0x0000_1006:
  - Required: daddr=0x0000_1004 stable for 4 cycles with dreq=1.
  - drdata=0xDEAD_BEEF → MEM_over one cycle after dack, rf_wdata=0xDEAD_BEEF.
- LB sign/zero extension, word 0x80FF_7F01:
  - addr[1:0]=2, lb_sign=1 → rf_wdata=0xFFFF_FFFF.
  - addr[1:0]=3, lb_sign=1 → 0xFFFF_FF80.
  - addr[1:0]=0, lb_sign=0 → 0x0000_0001.
- SB to addr 0x2003 with store_data=0x0000_00A5 → dwr=1, dwstrb=4'b1000, dwdata=0xA5A5_A5A5. SW gives dwstrb=4'b1111.
- Downstream stall: LW completes, WB_allow_in=0 for 5 cycles → MEM_over=1, rf_wdata constant, exactly one dreq/dack pair.
- Reset in WAIT: rst for 1 cycle → dreq=0 next cycle, state IDLE. A dack arriving afterwards causes no MEM_over.
